// File: rtl/select_data_param.sv
// NoC board stimulus injector: key-edited data/router values, streaming or one-shot
// packet injection with ack/timeout, and hex display. Optional debounce: SELECT_DATA_DEBOUNCE_EN.
`timescale 1ns/1ps

module select_data_param #(
   parameter int ROUTERS     = 9,
   parameter int DATA_W      = 8,
   parameter int DEB_CYCLES  = 16,
   parameter int ACK_TIMEOUT = 255,
   localparam int PKT_W      = DATA_W + 1,
   localparam int RW         = $clog2(ROUTERS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sw_on,
   input  logic                     sw_mode,
   input  logic                     sw_sel_data,
   input  logic                     sw_sel_router,
   input  logic                     key_inc,
   input  logic                     key_dec,
   input  logic                     key_send,
   input  logic [ROUTERS-1:0]       ack_router,
   output logic [ROUTERS*PKT_W-1:0] out_router,
   output logic                     busy,
   output logic                     err,
   output logic [6:0]               hex_data_lo,
   output logic [6:0]               hex_data_hi,
   output logic [6:0]               hex_router_lo,
   output logic [6:0]               hex_router_hi
);

   localparam int              TW       = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_INIT = TW'(ACK_TIMEOUT);
   localparam logic [RW-1:0]   R_MAX    = RW'(ROUTERS - 1);
   localparam logic [6:0]      SEG_ZERO = 7'b0000001;

   if (ROUTERS < 2 || ROUTERS > 256 || DATA_W < 1 || DEB_CYCLES < 1 || ACK_TIMEOUT < 1)
   begin : g_param_check
      $error("select_data_param: illegal parameter set");
   end

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_SEND, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [DATA_W-1:0]        data_q, data_d;
   logic [RW-1:0]            router_q, router_d;
   logic [DATA_W-1:0]        pkt_q, pkt_d;
   logic [RW-1:0]            dst_q, dst_d;
   logic [TW-1:0]            tmo_q, tmo_d;
   logic                     err_q, err_d;
   logic                     busy_q, busy_d;
   logic [ROUTERS*PKT_W-1:0] out_q, out_d;
   logic [6:0]               hdl_q, hdl_d, hdh_q, hdh_d, hrl_q, hrl_d, hrh_q, hrh_d;

   // Key bit order everywhere: {send, dec, inc}.
   logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [2:0] prev_q, prev_d, edge_q, edge_d;
   logic [2:0] filt;
   logic       inc_e, dec_e, send_e;
   logic [7:0] data8, router8;

   always_comb begin
      sync1_d = {key_send, key_dec, key_inc};
      sync2_d = sync1_q;
      prev_d  = filt;
      edge_d  = filt & ~prev_q;
   end

`ifdef SELECT_DATA_DEBOUNCE_EN
   localparam int DCW = $clog2(DEB_CYCLES + 1);
   logic [DCW-1:0] deb_cnt_q [3];
   logic [DCW-1:0] deb_cnt_d [3];
   logic [2:0]     deb_lvl_q, deb_lvl_d;

   // The filtered level only follows after DEB_CYCLES consecutive differing samples.
   always_comb begin
      deb_lvl_d = deb_lvl_q;
      for (int k = 0; k < 3; k++) begin
         deb_cnt_d[k] = '0;
         if (sync2_q[k] != deb_lvl_q[k]) begin
            if (deb_cnt_q[k] == DCW'(DEB_CYCLES - 1)) deb_lvl_d[k] = sync2_q[k];
            else deb_cnt_d[k] = deb_cnt_q[k] + DCW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_lvl_q <= '0;
         for (int k = 0; k < 3; k++) deb_cnt_q[k] <= '0;
      end else begin
         deb_lvl_q <= deb_lvl_d;
         for (int k = 0; k < 3; k++) deb_cnt_q[k] <= deb_cnt_d[k];
      end
   end

   assign filt = deb_lvl_q;
`else
   assign filt = sync2_q;
`endif

   assign inc_e  = edge_q[0];
   assign dec_e  = edge_q[1];
   assign send_e = edge_q[2];

   always_comb begin
      data_d   = data_q;
      router_d = router_q;
      if (sw_sel_data) begin
         if (inc_e && !dec_e)      data_d = data_q + DATA_W'(1);
         else if (dec_e && !inc_e) data_d = data_q - DATA_W'(1);
      end else if (sw_sel_router) begin
         if (inc_e && !dec_e)      router_d = (router_q == R_MAX) ? '0 : router_q + RW'(1);
         else if (dec_e && !inc_e) router_d = (router_q == '0) ? R_MAX : router_q - RW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      dst_d   = dst_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (sw_on && !sw_mode) begin
               state_d = S_STREAM;
            end else if (sw_on && sw_mode && send_e) begin
               state_d = S_SEND;
               pkt_d   = data_q;
               dst_d   = router_q;
               err_d   = 1'b0;
               tmo_d   = TMO_INIT;
            end
         end
         S_STREAM: if (!sw_on || sw_mode) state_d = S_IDLE;
         S_SEND: begin
            // Ack is checked before the expiry test so a last-cycle ack wins.
            if (!sw_on) begin
               state_d = S_IDLE;
            end else if (ack_router[dst_q]) begin
               state_d = S_DONE;
            end else if (tmo_q == '0) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end
         S_DONE: if (!filt[2]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered against the next state so they line up with state_q.
   always_comb begin
      out_d = '0;
      for (int i = 0; i < ROUTERS; i++) begin
         if (state_d == S_STREAM && RW'(i) == router_q)
            out_d[i*PKT_W +: PKT_W] = {1'b1, data_q};
         if (state_d == S_SEND && RW'(i) == dst_d)
            out_d[i*PKT_W +: PKT_W] = {1'b1, pkt_d};
      end
      busy_d = (state_d == S_STREAM) || (state_d == S_SEND);
   end

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   always_comb begin
      data8   = 8'(data_q);
      router8 = 8'(router_q);
      hdl_d   = hex7(data8[3:0]);
      hdh_d   = hex7(data8[7:4]);
      hrl_d   = hex7(router8[3:0]);
      hrh_d   = hex7(router8[7:4]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         edge_q   <= '0;
         state_q  <= S_IDLE;
         data_q   <= '0;
         router_q <= '0;
         pkt_q    <= '0;
         dst_q    <= '0;
         tmo_q    <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         out_q    <= '0;
         hdl_q    <= SEG_ZERO;
         hdh_q    <= SEG_ZERO;
         hrl_q    <= SEG_ZERO;
         hrh_q    <= SEG_ZERO;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         edge_q   <= edge_d;
         state_q  <= state_d;
         data_q   <= data_d;
         router_q <= router_d;
         pkt_q    <= pkt_d;
         dst_q    <= dst_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         out_q    <= out_d;
         hdl_q    <= hdl_d;
         hdh_q    <= hdh_d;
         hrl_q    <= hrl_d;
         hrh_q    <= hrh_d;
      end
   end

   assign out_router    = out_q;
   assign busy          = busy_q;
   assign err           = err_q;
   assign hex_data_lo   = hdl_q;
   assign hex_data_hi   = hdh_q;
   assign hex_router_lo = hrl_q;
   assign hex_router_hi = hrh_q;

endmodule

// File: tb/tb_select_data_param.sv
// Directed + randomized bench for select_data_param with a value-level reference model.
`timescale 1ns/1ps

module tb_select_data_param;

   localparam int ROUTERS     = 9;
   localparam int DATA_W      = 8;
   localparam int PKT_W       = DATA_W + 1;
   localparam int ACK_TIMEOUT = 10;
   localparam int DEB_CYCLES  = 16;
`ifdef SELECT_DATA_DEBOUNCE_EN
   localparam int DEB = DEB_CYCLES;
`else
   localparam int DEB = 0;
`endif
   localparam int HOLD       = (DEB == 0) ? 1 : DEB + 2;
   localparam int SETTLE     = 2 * DEB + 8;
   localparam int LAT_EDGES  = 5 + DEB;
   localparam int OW         = ROUTERS * PKT_W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sw_on, sw_mode, sw_sel_data, sw_sel_router;
   logic          key_inc, key_dec, key_send;
   logic [ROUTERS-1:0] ack_router;
   logic [OW-1:0] out_router;
   logic          busy, err;
   logic [6:0]    hex_data_lo, hex_data_hi, hex_router_lo, hex_router_hi;

   int checks   = 0;
   int failures = 0;
   int m_data   = 0;
   int m_router = 0;

   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   select_data_param #(
      .ROUTERS(ROUTERS), .DATA_W(DATA_W), .DEB_CYCLES(DEB_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .sw_mode(sw_mode),
      .sw_sel_data(sw_sel_data), .sw_sel_router(sw_sel_router),
      .key_inc(key_inc), .key_dec(key_dec), .key_send(key_send),
      .ack_router(ack_router), .out_router(out_router), .busy(busy), .err(err),
      .hex_data_lo(hex_data_lo), .hex_data_hi(hex_data_hi),
      .hex_router_lo(hex_router_lo), .hex_router_hi(hex_router_hi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] slot(input int idx, input int val);
      logic [OW-1:0] v;
      v = '0;
      v[idx*PKT_W +: PKT_W] = PKT_W'(val);
      return v;
   endfunction

   task automatic check_hex(input string tag);
      chk({tag, "_hdl"}, 128'(hex_data_lo),   128'(seg_tab[m_data % 16]));
      chk({tag, "_hdh"}, 128'(hex_data_hi),   128'(seg_tab[(m_data / 16) % 16]));
      chk({tag, "_hrl"}, 128'(hex_router_lo), 128'(seg_tab[m_router % 16]));
      chk({tag, "_hrh"}, 128'(hex_router_hi), 128'(seg_tab[(m_router / 16) % 16]));
   endtask

   // Reference rule: data edits win over router edits; simultaneous inc+dec is a no-op.
   task automatic model_edit(input bit inc, input bit dec);
      int step;
      step = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
      if (sw_sel_data)        m_data   = (m_data + step + (1 << DATA_W)) % (1 << DATA_W);
      else if (sw_sel_router) m_router = (m_router + step + ROUTERS) % ROUTERS;
   endtask

   task automatic press(input bit inc, input bit dec);
      key_inc = inc;
      key_dec = dec;
      repeat (HOLD) @(negedge clk);
      key_inc = 1'b0;
      key_dec = 1'b0;
      repeat (SETTLE) @(negedge clk);
      model_edit(inc, dec);
   endtask

   task automatic set_data(input int target);
      sw_sel_data = 1'b1;
      sw_sel_router = 1'b0;
      while (m_data != target) begin
         if (((target - m_data + 256) % 256) <= 128) press(1'b1, 1'b0);
         else press(1'b0, 1'b1);
      end
   endtask

   task automatic set_router(input int target);
      sw_sel_data = 1'b0;
      sw_sel_router = 1'b1;
      while (m_router != target) press(1'b1, 1'b0);
   endtask

   task automatic wait_busy(output bit got);
      got = 1'b0;
      for (int i = 0; i < 40 + 2 * DEB; i++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit got;
      int n, bad, prev_data, err_seen;
      rst_n = 1'b0;
      sw_on = 1'b0; sw_mode = 1'b0; sw_sel_data = 1'b0; sw_sel_router = 1'b0;
      key_inc = 1'b0; key_dec = 1'b0; key_send = 1'b0;
      ack_router = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out", 128'(out_router), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      check_hex("rst");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_out", 128'(out_router), 128'(0));
      check_hex("idle");

      // Router +3 with exact key-to-display latency on the third press
      sw_sel_router = 1'b1;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      key_inc = 1'b1;
      for (int k = 1; k <= LAT_EDGES; k++) begin
         @(negedge clk);
         if (k == HOLD) key_inc = 1'b0;
         if (k == LAT_EDGES - 1) chk("lat_before", 128'(hex_router_lo), 128'(seg_tab[2]));
         if (k == LAT_EDGES)     chk("lat_after", 128'(hex_router_lo), 128'(7'b0000110));
      end
      model_edit(1'b1, 1'b0);
      repeat (SETTLE) @(negedge clk);
      check_hex("r3");

      // Wrap-around: router 0 -> 8, data 0 -> 255 (both selects high edits data only)
      sw_sel_router = 1'b1;
      repeat (3) press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      chk("rwrap", 128'(hex_router_lo), 128'(7'b0000000));
      sw_sel_data = 1'b1;
      press(1'b0, 1'b1);
      chk("dwrap_lo", 128'(hex_data_lo), 128'(7'b0111000));
      chk("dwrap_hi", 128'(hex_data_hi), 128'(7'b0111000));
      check_hex("wrap");

      // Randomized edits against the model
      for (int it = 0; it < 16; it++) begin
         int kind;
         sw_sel_data   = 1'($urandom_range(0, 1));
         sw_sel_router = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 2);
         press(kind != 1, kind != 0);
         check_hex("rand");
      end

`ifdef SELECT_DATA_DEBOUNCE_EN
      // Short glitch filtered, long press counted once
      sw_sel_data = 1'b1;
      prev_data = m_data;
      key_inc = 1'b1;
      repeat (5) @(negedge clk);
      key_inc = 1'b0;
      repeat (SETTLE) @(negedge clk);
      chk("glitch", 128'(hex_data_lo), 128'(seg_tab[prev_data % 16]));
      key_inc = 1'b1;
      repeat (20) @(negedge clk);
      key_inc = 1'b0;
      repeat (SETTLE) @(negedge clk);
      model_edit(1'b1, 1'b0);
      check_hex("press20");
`endif

      // Continuous streaming
      set_data(8'h5A);
      set_router(2);
      sw_mode = 1'b0;
      sw_on = 1'b1;
      repeat (3) @(negedge clk);
      chk("stream_out", 128'(out_router), 128'(slot(2, 9'h15A)));
      chk("stream_busy", 128'(busy), 128'(1));
      for (int it = 0; it < 4; it++) begin
         sw_sel_data   = 1'($urandom_range(0, 1));
         sw_sel_router = 1'b1;
         press(1'b1, 1'b0);
         chk("stream_live", 128'(out_router), 128'(slot(m_router, 256 + m_data)));
      end
      sw_on = 1'b0;
      @(negedge clk);
      chk("stream_off", 128'(out_router), 128'(0));
      chk("stream_off_busy", 128'(busy), 128'(0));

      // One-shot send with ack
      set_data(7);
      set_router(4);
      sw_mode = 1'b1;
      @(negedge clk);
      sw_on = 1'b1;
      repeat (2) @(negedge clk);
      chk("oneshot_idle", 128'(busy), 128'(0));
      key_send = 1'b1;
      wait_busy(got);
      chk("send_start", 128'(got), 128'(1));
      chk("send_pkt", 128'(out_router), 128'(slot(4, 9'h107)));
      ack_router[3] = 1'b1;
      repeat (3) @(negedge clk);
      chk("send_wrong_ack", 128'(out_router), 128'(slot(4, 9'h107)));
      chk("send_wrong_busy", 128'(busy), 128'(1));
      ack_router = '0;
      ack_router[4] = 1'b1;
      repeat (2) @(negedge clk);
      chk("ack_out", 128'(out_router), 128'(0));
      chk("ack_busy", 128'(busy), 128'(0));
      chk("ack_err", 128'(err), 128'(0));
      ack_router = '0;
      bad = 0;
      repeat (20 + DEB) begin
         @(negedge clk);
         if (out_router !== '0 || busy !== 1'b0) bad++;
      end
      chk("one_per_press", 128'(bad), 128'(0));
      key_send = 1'b0;
      repeat (SETTLE) @(negedge clk);

      // Timeout: SEND lasts ACK_TIMEOUT+1 cycles, err rises with DONE entry
      key_send = 1'b1;
      wait_busy(got);
      key_send = 1'b0;
      chk("tmo_start", 128'(got), 128'(1));
      n = 1;
      err_seen = int'(err);
      while (busy === 1'b1 && n < 60) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            n++;
            if (err === 1'b1) err_seen = 1;
         end
      end
      chk("tmo_len", 128'(n), 128'(ACK_TIMEOUT + 1));
      chk("tmo_err_early", 128'(err_seen), 128'(0));
      chk("tmo_err", 128'(err), 128'(1));
      chk("tmo_out", 128'(out_router), 128'(0));
      repeat (SETTLE) @(negedge clk);

      // Next send clears err; ack on the final counter cycle wins
      key_send = 1'b1;
      wait_busy(got);
      key_send = 1'b0;
      chk("clr_start", 128'(got), 128'(1));
      chk("clr_err", 128'(err), 128'(0));
      repeat (ACK_TIMEOUT) @(negedge clk);
      chk("last_busy", 128'(busy), 128'(1));
      ack_router[4] = 1'b1;
      @(negedge clk);
      ack_router = '0;
      chk("last_ack_busy", 128'(busy), 128'(0));
      chk("last_ack_err", 128'(err), 128'(0));
      repeat (SETTLE) @(negedge clk);

      // Abort by sw_on=0
      key_send = 1'b1;
      wait_busy(got);
      key_send = 1'b0;
      chk("abort_start", 128'(got), 128'(1));
      sw_on = 1'b0;
      @(negedge clk);
      chk("abort_out", 128'(out_router), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      repeat (SETTLE) @(negedge clk);
      sw_on = 1'b1;

      // Reset mid-SEND drops the packet at once
      key_send = 1'b1;
      wait_busy(got);
      key_send = 1'b0;
      chk("rst_send_start", 128'(got), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_send_out", 128'(out_router), 128'(0));
      chk("rst_send_busy", 128'(busy), 128'(0));
      chk("rst_send_hex", 128'(hex_data_lo), 128'(7'b0000001));
      @(negedge clk);
      rst_n = 1'b1;
      m_data = 0;
      m_router = 0;
      ack_router[4] = 1'b1;
      repeat (4) @(negedge clk);
      ack_router = '0;
      chk("post_rst_out", 128'(out_router), 128'(0));
      chk("post_rst_busy", 128'(busy), 128'(0));
      check_hex("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/select_data_param.md
# select_data_param

Parametrised stimulus injector for NoC board tests. Switches and keys set a data value and a target router index; the block places a one-hot-addressed packet `{1'b1, data}` on the selected router's input slot and drives four seven-segment digits. Two modes are supported: continuous streaming, and one-shot sends with an acknowledge handshake and timeout. It sits between the board I/O (switches, keys, HEX displays) and the router input ports of the generated network.

## Interface
Parameters:
- `ROUTERS`, 9: number of router slots; legal range 2..256.
- `DATA_W`, 8: payload width. Packet width `PKT_W = DATA_W+1`.
- `RW`, derived: `$clog2(ROUTERS)`, router index width.
- `DEB_CYCLES`, 16: debounce stability window, in clocks.
- `ACK_TIMEOUT`, 255: maximum number of cycles to wait for an acknowledge in one-shot mode.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sw_on`, in, 1: injection enable.
- `sw_mode`, in, 1: 0 selects continuous streaming; 1 selects one-shot.
- `sw_sel_data`, in, 1: the keys edit the data value.
- `sw_sel_router`, in, 1: the keys edit the router index.
- `key_inc`, `key_dec`, `key_send`, in, 1 each: active-high push buttons, asynchronous to `clk`.
- `ack_router`, in, ROUTERS: per-router acknowledge.
- `out_router`, out, ROUTERS*PKT_W: router `i` uses slice `[i*PKT_W +: PKT_W]`.
- `busy`, out, 1: high in the STREAM and SEND states.
- `err`, out, 1: sticky acknowledge-timeout flag.
- `hex_data_lo`, `hex_data_hi`, `hex_router_lo`, `hex_router_hi`, out, 7 each: hex digits of `data[7:0]` and `router` (zero-extended to 8 bits).

## Operation
- Key path: each key goes through a 2-flop synchronizer, then the optional debouncer, then a rising-edge detector.
- Data editing: applies when `sw_sel_data=1`.
  - `inc` edge: data+1, wrapping modulo 2^DATA_W.
  - `dec` edge: data-1, wrapping from 0 to 2^DATA_W-1.
  - `inc` and `dec` edges in the same cycle: no change.
- Router editing: applies when `sw_sel_router=1` and `sw_sel_data=0`.
  - `inc`: ROUTERS-1 wraps to 0.
  - `dec`: 0 wraps to ROUTERS-1.
  - When both select switches are high, only data is edited.
- FSM states: IDLE, STREAM, SEND, DONE.
  - IDLE: all slots are 0. `sw_on & ~sw_mode` moves to STREAM. `sw_on & sw_mode & send_edge` moves to SEND; this latches `data`/`router` into `pkt_q`/`dst_q`, clears `err`, and loads the timeout counter with ACK_TIMEOUT.
  - STREAM: slot[router] = `{1,data}` and all other slots are 0. Edits are tracked live. `~sw_on | sw_mode` moves to IDLE.
  - SEND: slot[dst_q] = `{1,pkt_q}`. Data/router edits are allowed but do not change `pkt_q`/`dst_q`. `ack_router[dst_q]` moves to DONE; acks on other routers are ignored. The counter decrements each cycle; when it reaches 0 with no ack, the block sets `err` and moves to DONE. `~sw_on` moves to IDLE (abort); `err` is unchanged on abort.
  - DONE: all slots are 0. The FSM waits for the filtered `key_send` to be low, then moves to IDLE. This guarantees one packet per press.
- Hex encoding: active-low, segments `{a,b,c,d,e,f,g}` with `a` as the MSB. Digits are 0-9 and A,b,C,d,E,F. `0` = 7'b0000001, `1` = 7'b1001111, `F` = 7'b0111000.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, `data`=0, `router`=0, `out_router`=0, `busy`=0, `err`=0.
  - all four hex outputs show `0` (7'b0000001).
  - synchronizer, debounce and edge flops are cleared.
- Asserting reset mid-SEND drops the packet immediately; no ack is expected afterwards.
- Key to register update, with debounce compiled out: a key rising at edge t updates `data`/`router` at edge t+3. The hex display changes at t+4.
- STREAM output: reflects a `data`/`router` change one cycle after the register updates, i.e. edge t+4.
- `out_router`, `busy`, `err` and the hex outputs are all registered; no combinational paths run from inputs to outputs.
- SEND entry: the packet appears on the cycle after the send edge is detected.
- ack handling:
  - `ack_router[dst_q]` sampled high at edge e means slots are 0 and `busy`=0 from edge e+1.
  - With no ack, SEND lasts exactly ACK_TIMEOUT+1 cycles; `err` rises together with the entry to DONE.
- ack arriving in the same cycle the counter reaches 0: the ack wins and `err` stays 0.

## Configuration
- `SELECT_DATA_DEBOUNCE_EN` defined:
  - each synchronized key must hold a new level for DEB_CYCLES consecutive cycles before the filtered level changes.
  - glitches shorter than that are ignored.
  - latency becomes t+3+DEB_CYCLES.
- Undefined: the synchronizer output is used directly. This is for simulation speed.

## Test plan
- Reset then idle: all outputs 0 and every hex output reads 7'b0000001. Three `key_inc` pulses with `sw_sel_router=1` and ROUTERS=9 give router=3 and `hex_router_lo`=7'b0000110.
- Wrap-around: router=0 with `key_dec` gives router=8. data=0 with `key_dec` and DATA_W=8 gives data=255 and both data digits read `F`.
- Continuous mode: sw_on=1, mode=0, data=0x5A, router=2 gives slice[2]=9'h15A, all other slices 0 and `busy`=1. Setting sw_on=0 gives all slices 0 one cycle later.
- One-shot send with ack: mode=1, data=7, router=4, `key_send` pulse. Slice[4]=9'h107 until `ack_router[4]` is raised; `ack_router[3]` has no effect. After the ack, slices are 0 and no second packet appears while the key is held.
- Timeout: no ack with ACK_TIMEOUT=10 gives SEND for 11 cycles, then `err`=1. The next accepted send clears `err`.
- Bounce, with `SELECT_DATA_DEBOUNCE_EN` defined and DEB_CYCLES=16: a 5-cycle `key_inc` glitch causes no change. A 20-cycle press increments data exactly once.
